// File: rtl/lv_wdg_reg_scan_if.sv
// lv_wdg_reg_scan_if: wdg-scan read port between the register scanner (master)
// and the register access controller (slave).
interface lv_wdg_reg_scan_if #(
  parameter int unsigned REG_AW    = 7,
  parameter int unsigned REG_DW    = 8,
  parameter int unsigned REG_CRC_W = 8
);
  logic                 wdg_scan_rac_rd_req;
  logic [REG_AW-1:0]    wdg_scan_rac_addr;
  logic                 rac_wdg_scan_ack;
  logic [REG_DW-1:0]    rac_wdg_scan_data;
  logic [REG_CRC_W-1:0] rac_wdg_scan_crc;

  modport master (
    output wdg_scan_rac_rd_req, wdg_scan_rac_addr,
    input  rac_wdg_scan_ack, rac_wdg_scan_data, rac_wdg_scan_crc
  );

  modport slave (
    input  wdg_scan_rac_rd_req, wdg_scan_rac_addr,
    output rac_wdg_scan_ack, rac_wdg_scan_data, rac_wdg_scan_crc
  );
endinterface

// File: rtl/lv_wdg_reg_scan.sv
// lv_wdg_reg_scan: background register-integrity scanner and SPI-inactivity
// watchdog. Walks SCAN_START_ADDR..SCAN_END_ADDR, checks each register's stored
// CRC-8 (poly 0x07, init 0x00, MSB first), keeps sticky CRC/timeout flags and
// raises o_wdg_expire after WDG_TMO_CYC cycles without SPI activity.
// Optional build macro: LV_WDG_SCAN_ERR_CNT_EN enables the saturating error
// counter on o_scan_err_cnt; without it the output is tied to zero.
module lv_wdg_reg_scan #(
  parameter int unsigned       REG_AW          = 7,
  parameter int unsigned       REG_DW          = 8,
  parameter int unsigned       REG_CRC_W       = 8,
  parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h1F,
  parameter int unsigned       SCAN_GAP_CYC    = 16,
  parameter int unsigned       ACK_TMO_CYC     = 64,
  parameter int unsigned       WDG_TMO_CYC     = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_scan_en,
  input  logic              i_err_clr,
  lv_wdg_reg_scan_if.master rac,
  input  logic              i_spi_rst_wdg,
  output logic              o_scan_pass_done,
  output logic              o_scan_crc_err,
  output logic              o_scan_tmo_err,
  output logic [REG_AW-1:0] o_scan_err_addr,
  output logic [7:0]        o_scan_err_cnt,
  output logic              o_wdg_expire
);

  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_REQ, ST_CHK} state_e;

  localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP_CYC - 1);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TMO_CYC - 1);
  localparam logic [15:0] WDG_LIM  = 16'(WDG_TMO_CYC);

  // CRC-8, poly 0x07, init 0x00, MSB first, no reflection, no xor-out
  function automatic logic [7:0] crc8_f(input logic [REG_DW-1:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = REG_DW - 1; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  state_e               state_q, state_d;
  logic [REG_AW-1:0]    addr_q, addr_d;
  logic [15:0]          gap_cnt_q, gap_cnt_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic                 rd_req_q, rd_req_d;
  logic [REG_DW-1:0]    data_q, data_d;
  logic [REG_CRC_W-1:0] crc_q, crc_d;
  logic                 pass_q, pass_d;
  logic                 crc_err_q, crc_err_d;
  logic                 tmo_err_q, tmo_err_d;
  logic [REG_AW-1:0]    err_addr_q, err_addr_d;
  logic [15:0]          wdg_cnt_q, wdg_cnt_d;
  logic                 wdg_exp_q, wdg_exp_d;
  logic                 crc_hit_s, tmo_hit_s, err_hit_s, step_s;

  // Scan FSM next state, request handshake and address stepping
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    gap_cnt_d = gap_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    rd_req_d  = rd_req_q;
    data_d    = data_q;
    crc_d     = crc_q;
    pass_d    = 1'b0;
    crc_hit_s = 1'b0;
    tmo_hit_s = 1'b0;
    step_s    = 1'b0;
    if (!i_scan_en) begin
      // disable wins everywhere; a late ack is simply never looked at
      state_d  = ST_IDLE;
      rd_req_d = 1'b0;
      addr_d   = SCAN_START_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_GAP;
          addr_d    = SCAN_START_ADDR;
          gap_cnt_d = 16'd0;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = ST_REQ;
            rd_req_d  = 1'b1;
            tmo_cnt_d = 16'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 16'd1;
          end
        end
        ST_REQ: begin
          if (rac.rac_wdg_scan_ack) begin
            data_d   = rac.rac_wdg_scan_data;
            crc_d    = rac.rac_wdg_scan_crc;
            rd_req_d = 1'b0;
            state_d  = ST_CHK;
          end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_hit_s = 1'b1;
            rd_req_d  = 1'b0;
            step_s    = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
        end
        ST_CHK: begin
          crc_hit_s = (crc8_f(data_q) != crc_q);
          step_s    = 1'b1;
        end
        default: begin
          state_d  = ST_IDLE;
          rd_req_d = 1'b0;
        end
      endcase
      // after a check or a timeout: move to the next address and rest in GAP
      if (step_s) begin
        state_d   = ST_GAP;
        gap_cnt_d = 16'd0;
        if (addr_q == SCAN_END_ADDR) begin
          addr_d = SCAN_START_ADDR;
          pass_d = 1'b1;
        end else begin
          addr_d = addr_q + REG_AW'(1);
        end
      end else begin
        pass_d = 1'b0;
      end
    end
  end

  assign err_hit_s = crc_hit_s | tmo_hit_s;

  // Sticky error flags and first-error address; a new error beats a clear
  always_comb begin
    crc_err_d  = crc_err_q;
    tmo_err_d  = tmo_err_q;
    err_addr_d = err_addr_q;
    if (i_err_clr) begin
      crc_err_d  = crc_hit_s;
      tmo_err_d  = tmo_hit_s;
      err_addr_d = err_hit_s ? addr_q : '0;
    end else begin
      crc_err_d = crc_err_q | crc_hit_s;
      tmo_err_d = tmo_err_q | tmo_hit_s;
      if (err_hit_s && !crc_err_q && !tmo_err_q) err_addr_d = addr_q;
      else                                       err_addr_d = err_addr_q;
    end
  end

  // SPI-idle watchdog: saturating counter, activity pulse restarts it
  always_comb begin
    if (i_spi_rst_wdg)             wdg_cnt_d = 16'd0;
    else if (wdg_cnt_q != WDG_LIM) wdg_cnt_d = wdg_cnt_q + 16'd1;
    else                           wdg_cnt_d = wdg_cnt_q;
    wdg_exp_d = (wdg_cnt_d == WDG_LIM);
  end

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= SCAN_START_ADDR;
      gap_cnt_q  <= 16'd0;
      tmo_cnt_q  <= 16'd0;
      rd_req_q   <= 1'b0;
      data_q     <= '0;
      crc_q      <= '0;
      pass_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      err_addr_q <= '0;
      wdg_cnt_q  <= 16'd0;
      wdg_exp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      gap_cnt_q  <= gap_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rd_req_q   <= rd_req_d;
      data_q     <= data_d;
      crc_q      <= crc_d;
      pass_q     <= pass_d;
      crc_err_q  <= crc_err_d;
      tmo_err_q  <= tmo_err_d;
      err_addr_q <= err_addr_d;
      wdg_cnt_q  <= wdg_cnt_d;
      wdg_exp_q  <= wdg_exp_d;
    end
  end

`ifdef LV_WDG_SCAN_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating error counter; a clear coinciding with an error restarts at 1
  always_comb begin
    if (i_err_clr)                        err_cnt_d = err_hit_s ? 8'd1 : 8'd0;
    else if (err_hit_s && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    else                                  err_cnt_d = err_cnt_q;
  end

  // Error counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_cnt_q <= 8'd0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign o_scan_err_cnt = err_cnt_q;
`else
  assign o_scan_err_cnt = 8'h00;
`endif

  assign rac.wdg_scan_rac_rd_req = rd_req_q;
  assign rac.wdg_scan_rac_addr   = addr_q;
  assign o_scan_pass_done        = pass_q;
  assign o_scan_crc_err          = crc_err_q;
  assign o_scan_tmo_err          = tmo_err_q;
  assign o_scan_err_addr         = err_addr_q;
  assign o_wdg_expire            = wdg_exp_q;

endmodule

// File: tb/tb_lv_wdg_reg_scan.sv
// tb_lv_wdg_reg_scan: directed bench for lv_wdg_reg_scan with a behavioural
// reference model compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_lv_wdg_reg_scan;

  localparam int START = 0;
  localparam int ENDA  = 3;
  localparam int GAP   = 4;
  localparam int TMO   = 8;
  localparam int WDG   = 100;
`ifdef LV_WDG_SCAN_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       scan_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       spi_rst = 1'b0;
  logic       pass_done, crc_err, tmo_err, wdg_expire;
  logic [6:0] err_addr;
  logic [7:0] err_cnt;

  lv_wdg_reg_scan_if #(.REG_AW(7), .REG_DW(8), .REG_CRC_W(8)) rac_if ();

  lv_wdg_reg_scan #(
    .REG_AW(7), .REG_DW(8), .REG_CRC_W(8),
    .SCAN_START_ADDR(7'h00), .SCAN_END_ADDR(7'h03),
    .SCAN_GAP_CYC(GAP), .ACK_TMO_CYC(TMO), .WDG_TMO_CYC(WDG)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scan_en(scan_en), .i_err_clr(err_clr),
    .rac(rac_if), .i_spi_rst_wdg(spi_rst),
    .o_scan_pass_done(pass_done), .o_scan_crc_err(crc_err),
    .o_scan_tmo_err(tmo_err), .o_scan_err_addr(err_addr),
    .o_scan_err_cnt(err_cnt), .o_wdg_expire(wdg_expire)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pass_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference CRC-8 as remainder of (d * x^8) mod (x^8 + x^2 + x + 1)
  function automatic logic [7:0] crc_ref(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int b = 15; b >= 8; b--)
      if (r[b]) r = r ^ (16'h0107 << (b - 8));
    return r[7:0];
  endfunction

  // ---------------- behavioural model ----------------
  bit   m_active, m_req, m_chk, m_pass, m_crc, m_tmo;
  int   m_gap, m_wait, m_addr, m_eaddr, m_cnt, m_wdg;
  logic [7:0] m_d, m_c;
  bit   e_crc, e_tmo, stepped;
  int   where;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_req = 0; m_chk = 0; m_pass = 0; m_crc = 0; m_tmo = 0;
      m_gap = 0; m_wait = 0; m_addr = START; m_eaddr = 0; m_cnt = 0; m_wdg = 0;
      m_d = 8'h00; m_c = 8'h00;
    end else begin
      e_crc = 0; e_tmo = 0; stepped = 0; where = m_addr; m_pass = 0;
      if (!scan_en) begin
        m_active = 0; m_req = 0; m_chk = 0; m_addr = START;
      end else if (!m_active) begin
        m_active = 1; m_gap = GAP; m_addr = START;
      end else if (m_chk) begin
        e_crc = (crc_ref(m_d) != m_c); m_chk = 0; stepped = 1;
      end else if (m_req) begin
        if (rac_if.rac_wdg_scan_ack) begin
          m_req = 0; m_chk = 1;
          m_d = rac_if.rac_wdg_scan_data; m_c = rac_if.rac_wdg_scan_crc;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin e_tmo = 1; m_req = 0; stepped = 1; end
        end
      end else begin
        m_gap--;
        if (m_gap == 0) begin m_req = 1; m_wait = 0; end
      end
      if (stepped) begin
        m_gap = GAP;
        if (m_addr == ENDA) begin m_addr = START; m_pass = 1; end
        else m_addr++;
      end
      if (err_clr) begin
        m_crc = e_crc; m_tmo = e_tmo;
        m_eaddr = (e_crc || e_tmo) ? where : 0;
        m_cnt = (e_crc || e_tmo) ? 1 : 0;
      end else if (e_crc || e_tmo) begin
        if (!m_crc && !m_tmo) m_eaddr = where;
        m_crc = m_crc | e_crc; m_tmo = m_tmo | e_tmo;
        if (m_cnt < 255) m_cnt++;
      end
      if (spi_rst) m_wdg = 0;
      else if (m_wdg < WDG) m_wdg++;
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_req",    rac_if.wdg_scan_rac_rd_req, m_req);
      chk("addr",      rac_if.wdg_scan_rac_addr, m_addr);
      chk("pass_done", pass_done, m_pass);
      chk("crc_err",   crc_err, m_crc);
      chk("tmo_err",   tmo_err, m_tmo);
      chk("err_addr",  err_addr, m_eaddr);
      chk("err_cnt",   err_cnt, CNT_EN ? m_cnt : 0);
      chk("expire",    wdg_expire, (m_wdg == WDG));
      if (pass_done) pass_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_req(output bit ok);
    int n;
    n = 0; ok = 1;
    while (rac_if.wdg_scan_rac_rd_req !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        vectors++; miscompares++; ok = 0;
        $display("FAIL wait_req: no read request within 200 cycles");
        return;
      end
    end
  endtask

  task automatic serve(input int delay, input logic [7:0] d, input logic [7:0] c, output int a);
    bit ok;
    a = -1;
    wait_req(ok);
    if (!ok) return;
    a = int'(rac_if.wdg_scan_rac_addr);
    repeat (delay) @(negedge clk);
    rac_if.rac_wdg_scan_ack = 1'b1; rac_if.rac_wdg_scan_data = d; rac_if.rac_wdg_scan_crc = c;
    @(negedge clk);
    rac_if.rac_wdg_scan_ack = 1'b0;
    chk("req_drop_after_ack", rac_if.wdg_scan_rac_rd_req, 1'b0);
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic wdg_window();
    int k;
    @(negedge clk); spi_rst = 1'b1;
    @(negedge clk); spi_rst = 1'b0;
    chk("wdg_cleared", wdg_expire, 1'b0);
    k = 0;
    while (wdg_expire !== 1'b1 && k <= 200) begin @(negedge clk); k++; end
    chk("wdg_expire_cycle", k, WDG);
  endtask

  int a, n;
  bit ok;
  int exp_a [5] = '{0, 1, 2, 3, 0};
  int dly   [5] = '{0, 1, 3, 2, 0};

  initial begin
    rac_if.rac_wdg_scan_ack = 1'b0;
    rac_if.rac_wdg_scan_data = 8'h00;
    rac_if.rac_wdg_scan_crc = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", rac_if.wdg_scan_rac_rd_req, 1'b0);
    chk("rst_addr", rac_if.wdg_scan_rac_addr, 7'h00);
    chk("rst_flags", {pass_done, crc_err, tmo_err, wdg_expire}, 4'b0000);
    chk("rst_err_addr", err_addr, 7'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);
    chk("crc_ref_a5", crc_ref(8'hA5), 8'h72);
    rst_n = 1'b1;
    scan_en = 1'b1;

    // full pass with good CRCs, varied ack latency
    for (int i = 0; i < 5; i++) begin
      serve(dly[i], 8'h10 + 8'(i), crc_ref(8'h10 + 8'(i)), a);
      chk("scan_addr", a, exp_a[i]);
    end
    chk("pass_count", pass_seen, 1);
    chk("no_errors", {crc_err, tmo_err}, 2'b00);

    // CRC mismatch at 2, then another at 3
    serve(1, 8'h55, crc_ref(8'h55), a);
    chk("addr1", a, 1);
    serve(0, 8'hA5, 8'h00, a);
    chk("addr2", a, 2);
    chk("crc_err_not_yet", crc_err, 1'b0);
    @(negedge clk);
    chk("crc_err_set", crc_err, 1'b1);
    chk("err_addr_2", err_addr, 7'h02);
    serve(2, 8'h3C, crc_ref(8'h3C) ^ 8'hFF, a);
    @(negedge clk);
    chk("err_addr_kept", err_addr, 7'h02);
    pulse_clr();
    chk("clr_crc_err", crc_err, 1'b0);
    chk("clr_err_addr", err_addr, 7'h00);

    // ack timeout at 1
    serve(0, 8'h01, crc_ref(8'h01), a);
    chk("addr0", a, 0);
    wait_req(ok);
    chk("tmo_req_addr", rac_if.wdg_scan_rac_addr, 7'h01);
    n = 0;
    while (rac_if.wdg_scan_rac_rd_req === 1'b1 && n <= 50) begin @(negedge clk); n++; end
    chk("tmo_len", n, TMO);
    chk("tmo_err_set", tmo_err, 1'b1);
    chk("tmo_err_addr", err_addr, 7'h01);
    serve(0, 8'h02, crc_ref(8'h02), a);
    chk("after_tmo_addr", a, 2);
    pulse_clr();

    // disable during REQ, stray ack, re-enable
    wait_req(ok);
    chk("req_addr3", rac_if.wdg_scan_rac_addr, 7'h03);
    scan_en = 1'b0;
    @(negedge clk);
    chk("dis_req_drop", rac_if.wdg_scan_rac_rd_req, 1'b0);
    rac_if.rac_wdg_scan_ack = 1'b1; rac_if.rac_wdg_scan_data = 8'hA5; rac_if.rac_wdg_scan_crc = 8'h00;
    @(negedge clk);
    rac_if.rac_wdg_scan_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_ack_flags", {crc_err, tmo_err}, 2'b00);
    scan_en = 1'b1;
    serve(0, 8'h77, crc_ref(8'h77), a);
    chk("restart_addr", a, 0);

    // watchdog: expiry exactly WDG cycles after activity, twice
    wdg_window();
    wdg_window();
    pulse_clr();

    // 300 forced CRC errors, then clear coinciding with an error
    for (int i = 0; i < 300; i++)
      serve(0, 8'(i), crc_ref(8'(i)) ^ 8'h5A, a);
    @(negedge clk);
    chk("cnt_sat", err_cnt, CNT_EN ? 8'hFF : 8'h00);
    chk("crc_err_300", crc_err, 1'b1);
    serve(0, 8'hC3, 8'h00, a);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_vs_err_flag", crc_err, 1'b1);
    chk("clr_vs_err_cnt", err_cnt, CNT_EN ? 8'h01 : 8'h00);
    chk("clr_vs_err_addr", err_addr, a);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
